// File: rtl/pingpong_buf_ctrl.sv
// Ping-pong sequencer for two dual-port RAM banks with a 2-entry output skid buffer.
// Define PP_PARTIAL_FLUSH_EN to add wr_flush, which closes a partially filled bank early.
module pingpong_buf_ctrl #(
    parameter int DW    = 4,
    parameter int AW    = 10,
    parameter int DEPTH = 1024
) (
    input  logic          clk_100,
    input  logic          rst_n,
`ifdef PP_PARTIAL_FLUSH_EN
    input  logic          wr_flush,
`endif
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    input  logic          rd_ready,
    output logic [1:0]    ram_wea,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_wdata,
    output logic [1:0]    ram_enb,
    output logic [AW-1:0] ram_raddr,
    input  logic [DW-1:0] ram_douta,
    input  logic [DW-1:0] ram_doutb,
    output logic [1:0]    bank_full,
    output logic          frame_done
);

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    bank_state_t   state_q [2];
    bank_state_t   state_d [2];
    logic          wr_bank_q;
    logic          rd_bank_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic          inflight_q;
    logic          inflight_bank_q;
    logic          frame_done_q;
    logic [DW-1:0] skid_mem [2];
    logic          skid_head_q;
    logic [1:0]    skid_count_q;

    bank_state_t   wr_state;
    bank_state_t   rd_state;
    logic          accept;
    logic          flush_close;
    logic          wr_close;
    logic [AW-1:0] rd_last;
    logic          can_drain;
    logic          pop;
    logic          push;
    logic [DW-1:0] push_data;
    logic [2:0]    occupancy;
    logic          rd_issue;
    logic          rd_close;

    assign wr_state  = state_q[wr_bank_q];
    assign rd_state  = state_q[rd_bank_q];
    assign wr_ready  = (wr_state == EMPTY) || (wr_state == FILLING);
    assign accept    = wr_valid && wr_ready;
    assign wr_close  = (accept && (wr_ptr_q == LAST_IDX)) || flush_close;

`ifdef PP_PARTIAL_FLUSH_EN
    logic [AW-1:0] bank_last [2];
    logic [AW-1:0] close_last;

    // A FILLING bank always holds at least one word, so wr_ptr-1 never underflows.
    assign flush_close = wr_flush && (wr_state == FILLING);
    assign close_last  = accept ? wr_ptr_q : (wr_ptr_q - PTR_ONE);
    assign rd_last     = bank_last[rd_bank_q];

    always_ff @(posedge clk_100) begin
        if (!rst_n) begin
            bank_last[0] <= LAST_IDX;
            bank_last[1] <= LAST_IDX;
        end else if (wr_close) begin
            bank_last[wr_bank_q] <= close_last;
        end
    end
`else
    assign flush_close = 1'b0;
    assign rd_last     = LAST_IDX;
`endif

    // Reads in flight count against skid space; a same-cycle pop frees a slot for full throughput.
    assign can_drain = (rd_state == FULL) || (rd_state == DRAINING);
    assign pop       = rd_valid && rd_ready;
    assign occupancy = {1'b0, skid_count_q} + {2'b00, inflight_q};
    assign rd_issue  = can_drain && (occupancy < (3'd2 + {2'b00, pop}));
    assign rd_close  = rd_issue && (rd_ptr_q == rd_last);
    assign push      = inflight_q;
    assign push_data = inflight_bank_q ? ram_doutb : ram_douta;

    always_comb begin
        state_d[0] = state_q[0];
        state_d[1] = state_q[1];
        if (wr_close) begin
            state_d[wr_bank_q] = FULL;
        end else if (accept) begin
            state_d[wr_bank_q] = FILLING;
        end
        if (rd_close) begin
            state_d[rd_bank_q] = EMPTY;
        end else if (can_drain) begin
            state_d[rd_bank_q] = DRAINING;
        end
    end

    always_comb begin
        ram_wea = 2'b00;
        ram_enb = 2'b00;
        if (accept) begin
            ram_wea[wr_bank_q] = 1'b1;
        end
        if (rd_issue) begin
            ram_enb[rd_bank_q] = 1'b1;
        end
    end

    assign ram_waddr    = wr_ptr_q;
    assign ram_wdata    = accept ? wr_data : '0;
    assign ram_raddr    = rd_ptr_q;
    assign bank_full[0] = (state_q[0] == FULL) || (state_q[0] == DRAINING);
    assign bank_full[1] = (state_q[1] == FULL) || (state_q[1] == DRAINING);
    assign frame_done   = frame_done_q;
    assign rd_valid     = (skid_count_q != 2'd0);
    assign rd_data      = skid_mem[skid_head_q];

    always_ff @(posedge clk_100) begin
        if (!rst_n) begin
            state_q[0] <= EMPTY;
            state_q[1] <= EMPTY;
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
        end
    end

    always_ff @(posedge clk_100) begin
        if (!rst_n) begin
            wr_bank_q       <= 1'b0;
            rd_bank_q       <= 1'b0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_bank_q <= 1'b0;
            frame_done_q    <= 1'b0;
        end else begin
            if (wr_close) begin
                wr_ptr_q  <= '0;
                wr_bank_q <= ~wr_bank_q;
            end else if (accept) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (rd_close) begin
                rd_ptr_q  <= '0;
                rd_bank_q <= ~rd_bank_q;
            end else if (rd_issue) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            inflight_q      <= rd_issue;
            inflight_bank_q <= rd_bank_q;
            frame_done_q    <= rd_close;
        end
    end

    // Writing at head+count lands in the free slot even when the head pops this cycle.
    always_ff @(posedge clk_100) begin
        if (!rst_n) begin
            skid_mem[0]  <= '0;
            skid_mem[1]  <= '0;
            skid_head_q  <= 1'b0;
            skid_count_q <= 2'd0;
        end else begin
            if (push) begin
                skid_mem[skid_head_q ^ skid_count_q[0]] <= push_data;
            end
            skid_head_q  <= skid_head_q ^ pop;
            skid_count_q <= skid_count_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_pingpong_buf_ctrl.sv
// Self-checking bench for pingpong_buf_ctrl (DEPTH=8, DW=4) with behavioural RAM banks.
// Covers the wr_flush feature when PP_PARTIAL_FLUSH_EN is defined.
module tb_pingpong_buf_ctrl;

    localparam int DW    = 4;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk_100 = 1'b0;
    logic          rst_n;
    logic          wr_flush;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_ready;
    logic [1:0]    ram_wea;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wdata;
    logic [1:0]    ram_enb;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_douta;
    logic [DW-1:0] ram_doutb;
    logic [1:0]    bank_full;
    logic          frame_done;

    logic [DW-1:0] mem_a [DEPTH];
    logic [DW-1:0] mem_b [DEPTH];

    int n_checks = 0;
    int n_pass   = 0;
    int wr_sent  = 0;
    int rd_got   = 0;
    int n_words  = 0;
    int frames   = 0;
    int bf0_at   = -1;
    bit bf0_seen = 1'b0;

    typedef struct {
        logic          rst_n;
        logic          wr_valid;
        logic [DW-1:0] wr_data;
        logic          exp_wr_ready;
        logic [1:0]    exp_wea;
        logic [AW-1:0] exp_waddr;
        logic [1:0]    exp_enb;
        logic [1:0]    exp_bank_full;
        logic          exp_rd_valid;
        logic [DW-1:0] exp_rd_data;
    } vec_t;

    vec_t vecs [13];

    always #5 clk_100 = ~clk_100;

    pingpong_buf_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk_100   (clk_100),
        .rst_n     (rst_n),
`ifdef PP_PARTIAL_FLUSH_EN
        .wr_flush  (wr_flush),
`endif
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_ready  (rd_ready),
        .ram_wea   (ram_wea),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_enb   (ram_enb),
        .ram_raddr (ram_raddr),
        .ram_douta (ram_douta),
        .ram_doutb (ram_doutb),
        .bank_full (bank_full),
        .frame_done(frame_done)
    );

    // Two simple-dual-port banks with one cycle of read latency.
    always @(posedge clk_100) begin
        if (ram_wea[0]) mem_a[ram_waddr] <= ram_wdata;
        if (ram_wea[1]) mem_b[ram_waddr] <= ram_wdata;
        if (ram_enb[0]) ram_douta <= mem_a[ram_raddr];
        if (ram_enb[1]) ram_doutb <= mem_b[ram_raddr];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // One cycle of producer/consumer traffic; rd_mode 0 = stalled, 1 = always ready, 2 = random.
    task automatic applyStimulus(input int rd_mode, input bit flush);
        @(posedge clk_100);
        #1;
        wr_valid = (wr_sent < n_words);
        wr_data  = 4'(wr_sent);
        rd_ready = (rd_mode == 1) || ((rd_mode == 2) && ($urandom_range(0, 1) == 1));
        wr_flush = flush;
        #3;
        if (bank_full[0] && !bf0_seen) begin
            bf0_seen = 1'b1;
            bf0_at   = wr_sent;
        end
        if (frame_done) frames++;
        if (rd_valid && rd_ready) begin
            checkOutput("rd_order", 32'(rd_data), 32'(rd_got % 16));
            rd_got++;
        end
        if (wr_valid && wr_ready) wr_sent++;
    endtask

    task automatic runUntil(input string name, input int rd_mode, input int target, input int budget);
        int cyc = 0;
        while ((rd_got < target) && (cyc < budget)) begin
            applyStimulus(rd_mode, 1'b0);
            cyc++;
        end
        checkOutput(name, 32'(rd_got), 32'(target));
    endtask

    task automatic resetDut(input int cycles);
        @(posedge clk_100);
        #1;
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        wr_flush = 1'b0;
        repeat (cycles) @(posedge clk_100);
        #1;
        rst_n    = 1'b1;
        wr_sent  = 0;
        rd_got   = 0;
        frames   = 0;
        bf0_seen = 1'b0;
        bf0_at   = -1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 4'd0, 1'b1, 2'b00, 3'd0, 2'b00, 2'b00, 1'b0, 4'd0};
        for (int k = 1; k <= 8; k++) begin
            vecs[k] = '{1'b1, 1'b1, 4'(k - 1), 1'b1, 2'b01, 3'(k - 1), 2'b00, 2'b00, 1'b0, 4'd0};
        end
        vecs[9]  = '{1'b1, 1'b0, 4'd0, 1'b1, 2'b00, 3'd0, 2'b01, 2'b01, 1'b0, 4'd0};
        vecs[10] = '{1'b1, 1'b1, 4'd8, 1'b1, 2'b10, 3'd0, 2'b01, 2'b01, 1'b0, 4'd0};
        vecs[11] = '{1'b1, 1'b0, 4'd0, 1'b1, 2'b00, 3'd1, 2'b00, 2'b01, 1'b1, 4'd0};
        vecs[12] = '{1'b1, 1'b0, 4'd0, 1'b1, 2'b00, 3'd1, 2'b00, 2'b01, 1'b1, 4'd0};

        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        wr_flush = 1'b0;
        repeat (3) @(posedge clk_100);

        $display("[TB] reset state and first frame fill (table)");
        for (int i = 0; i < 13; i++) begin
            @(posedge clk_100);
            #1;
            rst_n    = vecs[i].rst_n;
            wr_valid = vecs[i].wr_valid;
            wr_data  = vecs[i].wr_data;
            rd_ready = 1'b0;
            #3;
            checkOutput($sformatf("v%0d_wr_ready", i), 32'(wr_ready), 32'(vecs[i].exp_wr_ready));
            checkOutput($sformatf("v%0d_wea", i), 32'(ram_wea), 32'(vecs[i].exp_wea));
            checkOutput($sformatf("v%0d_waddr", i), 32'(ram_waddr), 32'(vecs[i].exp_waddr));
            checkOutput($sformatf("v%0d_enb", i), 32'(ram_enb), 32'(vecs[i].exp_enb));
            checkOutput($sformatf("v%0d_bank_full", i), 32'(bank_full), 32'(vecs[i].exp_bank_full));
            checkOutput($sformatf("v%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].exp_rd_valid));
            if (vecs[i].exp_wea != 2'b00) begin
                checkOutput($sformatf("v%0d_wdata", i), 32'(ram_wdata), 32'(vecs[i].wr_data));
            end
            if (vecs[i].exp_rd_valid) begin
                checkOutput($sformatf("v%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].exp_rd_data));
            end
        end

        $display("[TB] streaming 16 words with rd_ready high");
        resetDut(3);
        n_words = 16;
        runUntil("stream_count", 1, 16, 100);
        repeat (4) applyStimulus(1, 1'b0);
        checkOutput("stream_bf0_rise", 32'(bf0_at), 32'd8);
        checkOutput("stream_frame_done", 32'(frames), 32'd2);
        checkOutput("stream_bank_full_idle", 32'(bank_full), 32'd0);
        checkOutput("stream_wr_ready_idle", 32'(wr_ready), 32'd1);

        $display("[TB] consumer stall with 24 words offered");
        wr_sent = 0;
        rd_got  = 0;
        n_words = 24;
        repeat (40) applyStimulus(0, 1'b0);
        checkOutput("stall_wr_sent", 32'(wr_sent), 32'd16);
        checkOutput("stall_wr_ready", 32'(wr_ready), 32'd0);
        checkOutput("stall_bank_full", 32'(bank_full), 32'd3);
        checkOutput("stall_rd_got", 32'(rd_got), 32'd0);
        runUntil("stall_release_count", 1, 24, 200);
        repeat (4) applyStimulus(1, 1'b0);
        checkOutput("stall_release_wr_sent", 32'(wr_sent), 32'd24);
        checkOutput("stall_release_wr_ready", 32'(wr_ready), 32'd1);
        checkOutput("stall_release_bank_full", 32'(bank_full), 32'd0);

        $display("[TB] random consumer backpressure, 64 words");
        wr_sent = 0;
        rd_got  = 0;
        n_words = 64;
        runUntil("random_count", 2, 64, 2000);
        repeat (6) applyStimulus(1, 1'b0);
        checkOutput("random_no_dup", 32'(rd_got), 32'd64);
        checkOutput("random_wr_sent", 32'(wr_sent), 32'd64);

        $display("[TB] reset in the middle of draining bank B");
        resetDut(3);
        n_words = 16;
        runUntil("middrain_progress", 1, 13, 100);
        @(posedge clk_100);
        #1;
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        @(posedge clk_100);
        #3;
        checkOutput("middrain_bank_full", 32'(bank_full), 32'd0);
        checkOutput("middrain_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("middrain_wr_ready", 32'(wr_ready), 32'd1);
        @(posedge clk_100);
        #1;
        rst_n   = 1'b1;
        wr_sent = 0;
        rd_got  = 0;
        n_words = 8;
        runUntil("middrain_fresh_frame", 1, 8, 100);
        repeat (5) applyStimulus(1, 1'b0);
        checkOutput("middrain_no_extra", 32'(rd_got), 32'd8);

`ifdef PP_PARTIAL_FLUSH_EN
        $display("[TB] partial frame closed by wr_flush");
        resetDut(3);
        n_words = 3;
        repeat (3) applyStimulus(1, 1'b0);
        applyStimulus(1, 1'b1);
        repeat (20) applyStimulus(1, 1'b0);
        checkOutput("flush_len", 32'(rd_got), 32'd3);
        checkOutput("flush_bank_full", 32'(bank_full), 32'd0);
        @(posedge clk_100);
        #1;
        wr_valid = 1'b1;
        wr_data  = 4'd3;
        rd_ready = 1'b1;
        wr_flush = 1'b0;
        #3;
        checkOutput("flush_next_wea", 32'(ram_wea), 32'd2);
        checkOutput("flush_next_waddr", 32'(ram_waddr), 32'd0);
        @(posedge clk_100);
        #1;
        wr_valid = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
